mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port memory (Address/RW/Din/Dout bus) between two masters.
//  m0 is the CPU controller; m1 is a DMA/program loader.
//  A round-robin FSM issues one memory transaction per grant.
//  It returns read data to the owning master with a one-cycle rvalid pulse.
//  Sits between the masters and the memory model in the top-level bench/SoC.
// PARAMETERS
//  N        16  data width
//  AW       16  address width
//  MEM_LAT  1   memory read latency: edges after address sample until Din valid (>=1)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  reset       in   1   asynchronous, active-low reset
//  m0_req      in   1   m0 request; hold with addr/rw/wdata stable until m0_gnt
//  m0_addr     in   AW  m0 address
//  m0_rw       in   1   1=read, 0=write (memory convention)
//  m0_wdata    in   N   m0 write data
//  m0_gnt      out  1   one-cycle pulse: m0 transaction on memory bus this cycle
//  m0_rvalid   out  1   one-cycle pulse: m0_rdata valid
//  m0_rdata    out  N   read data to m0
//  m1_*        ---  --  identical set for master 1
//  Address     out  AW  memory address
//  RW          out  1   memory read/write, 0 = write
//  Dout        out  N   write data to memory Din
//  Din         in   N   read data from memory Dout
//  owner       out  1   master of current/last transaction
//  busy        out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset values:
//   - Outputs: all 0 except RW=1.
//   - State: state=IDLE, last_owner=1, so m0 wins the first tie.
//   - Reset is async and may assert in any state; an outstanding read is dropped (no rvalid).
//  States:
//   - IDLE -> ACCESS when any req is sampled high.
//   - ACCESS -> WAIT_RD when read; ACCESS -> IDLE when write.
//   - WAIT_RD -> IDLE after MEM_LAT edges; rvalid pulses in the cycle after leaving WAIT_RD.
//  Arbitration at edge k in IDLE:
//   - Exactly one req high: that master is selected.
//   - Both high: the master != last_owner is selected.
//   - last_owner and owner update on every grant.
//  ACCESS cycle (k..k+1), all registered at edge k:
//   - Address=addr; RW=rw; Dout=wdata (write) else hold; gnt of selected master =1.
//  Memory bus outside ACCESS:
//   - RW=1.
//   - Address and Dout hold last value.
//   - RW=0 for exactly one cycle per write, never otherwise.
//  Read return:
//   - Din is captured at edge k+1+MEM_LAT.
//   - <mX>_rdata=Din and <mX>_rvalid=1 for that one cycle.
//   - rdata holds afterwards; rvalid=0.
//  Latency:
//   - Write: req sample edge to gnt = 1 edge; occupancy 1 cycle.
//   - Read: gnt to rvalid = MEM_LAT+1 cycles.
//  Boundaries:
//   - req dropped before sampling edge: not served.
//   - Once sampled, the transaction completes even if req drops.
//   - Requests are ignored in ACCESS/WAIT_RD.
//   - Next arbitration happens in IDLE, min one IDLE cycle between transactions.
//   - Fairness: a continuously requesting master waits at most one other transaction.
//   - Never both gnt, never both rvalid.
// TESTING
//  1 m0 write 0x0010<=0xBEEF -> m0_gnt 1 cycle, Address=0x0010, RW=0 one cycle, Dout=0xBEEF;
//    then m0 read 0x0010 -> m0_rvalid 2 cycles after gnt, m0_rdata=0xBEEF, m1_rvalid never.
//  2 After reset, m0_req and m1_req held high -> grant sequence m0,m1,m0,m1; owner toggles accordingly.
//  3 Only m1_req held high, 4 reads -> four m1_gnt, zero m0_gnt; busy low exactly one cycle between.
//  4 Assert reset (low) in WAIT_RD -> no rvalid, RW=1, busy=0.
//    Release with both reqs high -> m0 granted first.
//  5 Instance MEM_LAT=3, m1 read 0x00FF (mem=0x1234) -> m1_rvalid exactly 4 cycles after m1_gnt, rdata=0x1234.
//  6 Random reqs, 1000 cycles, assertions:
//   - RW==0 only with a gnt whose rw==0.
//   - gnt and rvalid one-hot.
//   - No master waits more than one foreign transaction.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the two requesting masters, the arbiter and the single-port memory.
// The arbiter connects through the slave modport; masters and the memory model use master.
interface mem_arbiter_if #(
  parameter int N  = 16,
  parameter int AW = 16
);
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_rw;
  logic [N-1:0]  m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [N-1:0]  m0_rdata;

  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_rw;
  logic [N-1:0]  m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [N-1:0]  m1_rdata;

  logic [AW-1:0] Address;
  logic          RW;
  logic [N-1:0]  Dout;
  logic [N-1:0]  Din;
  logic          owner;
  logic          busy;

  modport slave (
    input  m0_req, m0_addr, m0_rw, m0_wdata,
    input  m1_req, m1_addr, m1_rw, m1_wdata,
    input  Din,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output Address, RW, Dout, owner, busy
  );

  modport master (
    output m0_req, m0_addr, m0_rw, m0_wdata,
    output m1_req, m1_addr, m1_rw, m1_wdata,
    output Din,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  Address, RW, Dout, owner, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two masters.
// Each grant issues one memory transaction; read data returns with a one-cycle rvalid pulse.
module mem_arbiter #(
  parameter int N       = 16,
  parameter int AW      = 16,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_RD
  } state_t;

  state_t        state_q;
  logic          lastOwner_q;
  logic [CW-1:0] cnt_q;

  logic          selM1;
  logic [AW-1:0] selAddr;
  logic          selRw;
  logic [N-1:0]  selWdata;

  // On a tie the master that did not own the previous grant wins.
  always_comb begin
    selM1    = (bus.m0_req && bus.m1_req) ? ~lastOwner_q : bus.m1_req;
    selAddr  = selM1 ? bus.m1_addr  : bus.m0_addr;
    selRw    = selM1 ? bus.m1_rw    : bus.m0_rw;
    selWdata = selM1 ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      lastOwner_q   <= 1'b1;
      cnt_q         <= '0;
      bus.Address   <= '0;
      bus.RW        <= 1'b1;
      bus.Dout      <= '0;
      bus.owner     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.RW        <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            state_q     <= ACCESS;
            bus.busy    <= 1'b1;
            bus.owner   <= selM1;
            lastOwner_q <= selM1;
            bus.Address <= selAddr;
            bus.RW      <= selRw;
            if (!selRw) bus.Dout <= selWdata;
            bus.m0_gnt  <= ~selM1;
            bus.m1_gnt  <= selM1;
          end
        end
        // RW still holds the granted direction throughout the ACCESS cycle.
        ACCESS: begin
          if (bus.RW) begin
            state_q <= WAIT_RD;
            cnt_q   <= CW'(MEM_LAT - 1);
          end else begin
            state_q  <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        WAIT_RD: begin
          if (cnt_q == '0) begin
            state_q  <= IDLE;
            bus.busy <= 1'b0;
            if (bus.owner) begin
              bus.m1_rdata  <= bus.Din;
              bus.m1_rvalid <= 1'b1;
            end else begin
              bus.m0_rdata  <= bus.Din;
              bus.m0_rvalid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
